phv_queue_arbiter: RTL and testbench

PHV_QUEUE_ARBITER -- requirements
Module: phv_queue_arbiter

---
 rtl/rmt_pkg.sv | 42 ++++
 rtl/phv_arb_fifo.sv | 83 ++++++++
 rtl/phv_queue_arbiter.sv | 175 +++++++++++++++++
 tb/tb_phv_queue_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_pkg.sv
// rmt_pkg -- constants and helpers shared by the match-action pipeline blocks.
//
// Contents:
//   RMT_PHV_LEN     default PHV width in bits
//   RMT_NUM_QUEUES  number of deparser queue ports
//   RMT_QID_W       width of a queue index
//   RMT_DROP_CNT_W  width of the per-queue drop counters
//   rr_grant_t      result of a round-robin search (found flag + index)
//   rr_pick()       round-robin search starting one past the last grant
package rmt_pkg;

    localparam int RMT_PHV_LEN    = 1024;
    localparam int RMT_NUM_QUEUES = 4;
    localparam int RMT_QID_W      = 2;
    localparam int RMT_DROP_CNT_W = 16;

    typedef struct packed {
        logic                 found;
        logic [RMT_QID_W-1:0] idx;
    } rr_grant_t;

    // Walks from the farthest candidate (last_grant itself) to the nearest
    // (last_grant+1) so that the nearest requester is the last one written
    // and therefore wins.
    function automatic rr_grant_t rr_pick(
        input logic [RMT_QID_W-1:0]      last_grant,
        input logic [RMT_NUM_QUEUES-1:0] req
    );
        rr_grant_t            g;
        logic [RMT_QID_W-1:0] idx;
        g = '0;
        for (int k = RMT_NUM_QUEUES; k >= 1; k--) begin
            idx = last_grant + RMT_QID_W'(k);
            if (req[idx]) begin
                g.found = 1'b1;
                g.idx   = idx;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/phv_arb_fifo.sv
// phv_arb_fifo -- per-queue PHV FIFO for the deparser queue arbiter.
//
// The head entry is presented combinationally on rd_data so the arbiter can
// load its output register in the cycle after a push lands.
// The caller decides acceptance: wr_en must only be raised when the FIFO is
// not full, or when it is full and rd_en is raised in the same cycle.
//
// Ports:
//   clk        clock, rising edge
//   srst       synchronous active-high reset (empties the FIFO)
//   wr_en      write wr_data at the tail
//   rd_en      drop the head entry (only while not empty)
//   wr_data    entry to write
//   rd_data    current head entry
//   full       occupancy == depth
//   empty      occupancy == 0
//   occupancy  number of stored entries, 0..depth
module phv_arb_fifo #(
    parameter int WIDTH      = 1024,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   occupancy
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (DEPTH_BITS+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_BITS+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    // On a full push+pop the write lands in the slot being read out, which
    // is safe because the read is taken before the clock edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data   = mem[rd_ptr_q];
    assign full      = (count_q == (DEPTH_BITS+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign occupancy = count_q;

endmodule

// File: rtl/phv_queue_arbiter.sv
// phv_queue_arbiter -- buffers PHVs from four pipeline queues and hands them
// to the deparser one at a time under round-robin arbitration.
//
// Optional feature: define PHV_ARB_DROP_CNT_EN to build the saturating
// per-queue drop counters; otherwise drop_cnt_N reads 0 and drops are silent.
//
// Ports:
//   axis_clk            sole clock, rising edge
//   reset               synchronous active-high reset
//   phv_in_N            PHV pushed into queue N (N = 0..3)
//   phv_in_valid_N      push strobe for queue N
//   phv_fifo_ready_N    queue N has at least two free slots
//   phv_out             granted PHV
//   phv_out_qid         queue that phv_out came from
//   phv_out_valid       phv_out / phv_out_qid are valid
//   phv_out_ready       deparser takes the PHV when high with phv_out_valid
//   drop_cnt_N          pushes discarded on queue N (saturating)
module phv_queue_arbiter
    import rmt_pkg::*;
#(
    parameter int PHV_LEN         = RMT_PHV_LEN,
    parameter int C_NUM_QUEUES    = RMT_NUM_QUEUES,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                      axis_clk,
    input  logic                      reset,
    input  logic [PHV_LEN-1:0]        phv_in_0,
    input  logic [PHV_LEN-1:0]        phv_in_1,
    input  logic [PHV_LEN-1:0]        phv_in_2,
    input  logic [PHV_LEN-1:0]        phv_in_3,
    input  logic                      phv_in_valid_0,
    input  logic                      phv_in_valid_1,
    input  logic                      phv_in_valid_2,
    input  logic                      phv_in_valid_3,
    output logic                      phv_fifo_ready_0,
    output logic                      phv_fifo_ready_1,
    output logic                      phv_fifo_ready_2,
    output logic                      phv_fifo_ready_3,
    output logic [PHV_LEN-1:0]        phv_out,
    output logic [RMT_QID_W-1:0]      phv_out_qid,
    output logic                      phv_out_valid,
    input  logic                      phv_out_ready,
    output logic [RMT_DROP_CNT_W-1:0] drop_cnt_0,
    output logic [RMT_DROP_CNT_W-1:0] drop_cnt_1,
    output logic [RMT_DROP_CNT_W-1:0] drop_cnt_2,
    output logic [RMT_DROP_CNT_W-1:0] drop_cnt_3
);

    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;
    // Upstream ORs the readies and may push one more beat after ready falls,
    // so ready drops while two slots are still free.
    localparam logic [FIFO_DEPTH_BITS:0] READY_MAX_OCC =
        (FIFO_DEPTH_BITS+1)'(FIFO_DEPTH - 2);

    logic [PHV_LEN-1:0]         phv_in_arr   [C_NUM_QUEUES];
    logic [PHV_LEN-1:0]         head_arr     [C_NUM_QUEUES];
    logic [FIFO_DEPTH_BITS:0]   occ_arr      [C_NUM_QUEUES];
    logic [RMT_DROP_CNT_W-1:0]  drop_cnt_arr [C_NUM_QUEUES];
    logic [C_NUM_QUEUES-1:0]    in_valid;
    logic [C_NUM_QUEUES-1:0]    fifo_wr;
    logic [C_NUM_QUEUES-1:0]    fifo_pop;
    logic [C_NUM_QUEUES-1:0]    fifo_full;
    logic [C_NUM_QUEUES-1:0]    fifo_empty;
    logic [C_NUM_QUEUES-1:0]    fifo_ready;

    logic [PHV_LEN-1:0]   out_data_q,   out_data_d;
    logic [RMT_QID_W-1:0] out_qid_q,    out_qid_d;
    logic                 out_valid_q,  out_valid_d;
    logic [RMT_QID_W-1:0] last_grant_q, last_grant_d;
    rr_grant_t            grant;

    assign phv_in_arr[0] = phv_in_0;
    assign phv_in_arr[1] = phv_in_1;
    assign phv_in_arr[2] = phv_in_2;
    assign phv_in_arr[3] = phv_in_3;
    assign in_valid      = {phv_in_valid_3, phv_in_valid_2, phv_in_valid_1, phv_in_valid_0};

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_QUEUES; gi++) begin : g_queue
            // A full FIFO still takes a push when its head leaves this cycle.
            assign fifo_wr[gi]    = in_valid[gi] && (!fifo_full[gi] || fifo_pop[gi]);
            assign fifo_ready[gi] = !reset && (occ_arr[gi] <= READY_MAX_OCC);

            phv_arb_fifo #(
                .WIDTH      (PHV_LEN),
                .DEPTH_BITS (FIFO_DEPTH_BITS)
            ) u_fifo (
                .clk       (axis_clk),
                .srst      (reset),
                .wr_en     (fifo_wr[gi]),
                .rd_en     (fifo_pop[gi]),
                .wr_data   (phv_in_arr[gi]),
                .rd_data   (head_arr[gi]),
                .full      (fifo_full[gi]),
                .empty     (fifo_empty[gi]),
                .occupancy (occ_arr[gi])
            );

`ifdef PHV_ARB_DROP_CNT_EN
            logic                      drop_evt;
            logic [RMT_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

            assign drop_evt = in_valid[gi] && !fifo_wr[gi];

            always_comb begin
                drop_cnt_d = drop_cnt_q;
                if (drop_evt && (drop_cnt_q != '1)) begin
                    drop_cnt_d = drop_cnt_q + RMT_DROP_CNT_W'(1);
                end
            end

            always_ff @(posedge axis_clk) begin
                if (reset) begin
                    drop_cnt_q <= '0;
                end else begin
                    drop_cnt_q <= drop_cnt_d;
                end
            end

            assign drop_cnt_arr[gi] = drop_cnt_q;
`else
            assign drop_cnt_arr[gi] = '0;
`endif
        end
    endgenerate

    // The output register reloads whenever it is empty or being taken this
    // cycle, which keeps back-to-back grants free of bubbles.
    always_comb begin
        out_data_d   = out_data_q;
        out_qid_d    = out_qid_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        fifo_pop     = '0;
        grant        = rr_pick(last_grant_q, ~fifo_empty);
        if (!out_valid_q || phv_out_ready) begin
            out_valid_d = grant.found;
            if (grant.found) begin
                out_data_d         = head_arr[grant.idx];
                out_qid_d          = grant.idx;
                last_grant_d       = grant.idx;
                fifo_pop[grant.idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (reset) begin
            out_data_q   <= '0;
            out_qid_q    <= '0;
            out_valid_q  <= 1'b0;
            // Starting at the last queue makes queue 0 the first to be served.
            last_grant_q <= RMT_QID_W'(C_NUM_QUEUES - 1);
        end else begin
            out_data_q   <= out_data_d;
            out_qid_q    <= out_qid_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign phv_out          = out_data_q;
    assign phv_out_qid      = out_qid_q;
    assign phv_out_valid    = out_valid_q;
    assign phv_fifo_ready_0 = fifo_ready[0];
    assign phv_fifo_ready_1 = fifo_ready[1];
    assign phv_fifo_ready_2 = fifo_ready[2];
    assign phv_fifo_ready_3 = fifo_ready[3];
    assign drop_cnt_0       = drop_cnt_arr[0];
    assign drop_cnt_1       = drop_cnt_arr[1];
    assign drop_cnt_2       = drop_cnt_arr[2];
    assign drop_cnt_3       = drop_cnt_arr[3];

endmodule

// File: tb/tb_phv_queue_arbiter.sv
// tb_phv_queue_arbiter -- directed self-checking bench for phv_queue_arbiter.
// A table of push patterns with hand-derived grant orders is applied first,
// followed by hand-written sequences for throughput, back-pressure with drops,
// push+pop on a full queue, and reset in the middle of traffic.
// Build with or without PHV_ARB_DROP_CNT_EN; the drop expectation follows it.
module tb_phv_queue_arbiter;

    localparam int W = 1024;
`ifdef PHV_ARB_DROP_CNT_EN
    localparam int EXP_DROP_Q1 = 1;
`else
    localparam int EXP_DROP_Q1 = 0;
`endif

    logic          axis_clk = 1'b0;
    logic          reset;
    logic [W-1:0]  phv_in_0, phv_in_1, phv_in_2, phv_in_3;
    logic          phv_in_valid_0, phv_in_valid_1, phv_in_valid_2, phv_in_valid_3;
    logic          phv_fifo_ready_0, phv_fifo_ready_1, phv_fifo_ready_2, phv_fifo_ready_3;
    logic [W-1:0]  phv_out;
    logic [1:0]    phv_out_qid;
    logic          phv_out_valid;
    logic          phv_out_ready;
    logic [15:0]   drop_cnt_0, drop_cnt_1, drop_cnt_2, drop_cnt_3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] sb [4][$];

    always #5 axis_clk = ~axis_clk;

    phv_queue_arbiter dut (
        .axis_clk         (axis_clk),
        .reset            (reset),
        .phv_in_0         (phv_in_0),
        .phv_in_1         (phv_in_1),
        .phv_in_2         (phv_in_2),
        .phv_in_3         (phv_in_3),
        .phv_in_valid_0   (phv_in_valid_0),
        .phv_in_valid_1   (phv_in_valid_1),
        .phv_in_valid_2   (phv_in_valid_2),
        .phv_in_valid_3   (phv_in_valid_3),
        .phv_fifo_ready_0 (phv_fifo_ready_0),
        .phv_fifo_ready_1 (phv_fifo_ready_1),
        .phv_fifo_ready_2 (phv_fifo_ready_2),
        .phv_fifo_ready_3 (phv_fifo_ready_3),
        .phv_out          (phv_out),
        .phv_out_qid      (phv_out_qid),
        .phv_out_valid    (phv_out_valid),
        .phv_out_ready    (phv_out_ready),
        .drop_cnt_0       (drop_cnt_0),
        .drop_cnt_1       (drop_cnt_1),
        .drop_cnt_2       (drop_cnt_2),
        .drop_cnt_3       (drop_cnt_3)
    );

    typedef struct {
        logic [3:0] mask;   // queues pushed together in one cycle
        int         n;      // number of beats expected
        logic [7:0] ord;    // expected qid of beat k in bits [2k+1:2k]
    } vec_t;

    function automatic logic [W-1:0] mk_phv(input int tag, input int q);
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) begin
            v[i*32 +: 32] = (32'(tag) << 20) ^ (32'(q) << 12) ^ 32'(i) ^ 32'hA500_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] rdy();
        return {phv_fifo_ready_3, phv_fifo_ready_2, phv_fifo_ready_1, phv_fifo_ready_0};
    endfunction

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic push(input int q, input logic [W-1:0] d);
        case (q)
            0:       begin phv_in_0 = d; phv_in_valid_0 = 1'b1; end
            1:       begin phv_in_1 = d; phv_in_valid_1 = 1'b1; end
            2:       begin phv_in_2 = d; phv_in_valid_2 = 1'b1; end
            default: begin phv_in_3 = d; phv_in_valid_3 = 1'b1; end
        endcase
    endtask

    task automatic clear_push();
        phv_in_valid_0 = 1'b0;
        phv_in_valid_1 = 1'b0;
        phv_in_valid_2 = 1'b0;
        phv_in_valid_3 = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_phv(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got low64 %h, expected low64 %h", name, act[63:0], exp[63:0]);
        end
    endtask

    task automatic chk_beat(input string name, input logic [1:0] qid, input logic [W-1:0] d);
        $display("[TB] %s: valid=%0b qid=%0d data_lo=%h", name, phv_out_valid, phv_out_qid, phv_out[31:0]);
        chk({name, "_valid"}, 64'(phv_out_valid), 64'd1);
        chk({name, "_qid"}, 64'(phv_out_qid), 64'(qid));
        chk_phv({name, "_data"}, phv_out, d);
    endtask

    // Compares the beat on the output against the oldest pushed entry of its queue.
    task automatic sb_check(input string name);
        int qi;
        qi = int'(phv_out_qid);
        $display("[TB] %s: qid=%0d data_lo=%h", name, qi, phv_out[31:0]);
        if (sb[qi].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: beat from qid %0d, expected none queued there", name, qi);
        end else begin
            chk_phv(name, phv_out, sb[qi].pop_front());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_push();
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        vec_t         vecs [10];
        logic [7:0]   ord;
        logic [1:0]   eq;
        logic [3:0]   r4;
        logic [W-1:0] d;
        int           exp_q;
        int           seq;
        int           total;

        // Orders derived by hand; last_grant carries over from row to row.
        vecs[0] = '{4'b0100, 1, 8'h02};   // 2                 last=2
        vecs[1] = '{4'b1111, 4, 8'h93};   // 3,0,1,2           last=2
        vecs[2] = '{4'b0011, 2, 8'h04};   // 0,1               last=1
        vecs[3] = '{4'b1001, 2, 8'h03};   // 3,0               last=0
        vecs[4] = '{4'b0001, 1, 8'h00};   // 0                 last=0
        vecs[5] = '{4'b0110, 2, 8'h09};   // 1,2               last=2
        vecs[6] = '{4'b1000, 1, 8'h03};   // 3                 last=3
        vecs[7] = '{4'b1010, 2, 8'h0D};   // 1,3               last=3
        vecs[8] = '{4'b0111, 3, 8'h24};   // 0,1,2             last=2
        vecs[9] = '{4'b1101, 3, 8'h23};   // 3,0,2             last=2

        reset         = 1'b1;
        phv_out_ready = 1'b1;
        phv_in_0 = '0; phv_in_1 = '0; phv_in_2 = '0; phv_in_3 = '0;
        clear_push();

        // ---- reset state ----
        step(); step(); step();
        chk("rst_valid", 64'(phv_out_valid), 64'd0);
        chk_phv("rst_data", phv_out, '0);
        chk("rst_qid", 64'(phv_out_qid), 64'd0);
        chk("rst_drop", {drop_cnt_3, drop_cnt_2, drop_cnt_1, drop_cnt_0}, 64'd0);
        chk("rst_ready", 64'(rdy()), 64'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 64'(rdy()), 64'hF);

        // ---- table: simultaneous pushes, round-robin order, latency, idle ----
        for (int r = 0; r < 10; r++) begin
            ord = vecs[r].ord;
            for (int q = 0; q < 4; q++) begin
                if (vecs[r].mask[q]) push(q, mk_phv(r, q));
            end
            step();
            clear_push();
            chk($sformatf("row%0d_not_yet", r), 64'(phv_out_valid), 64'd0);
            step();
            for (int k = 0; k < vecs[r].n; k++) begin
                eq = ord[2*k +: 2];
                chk_beat($sformatf("row%0d_beat%0d", r, k), eq, mk_phv(r, int'(eq)));
                step();
            end
            chk($sformatf("row%0d_idle", r), 64'(phv_out_valid), 64'd0);
        end

        // ---- all queues fed continuously: 0,1,2,3,... with no idle cycle ----
        do_reset();
        phv_out_ready = 1'b1;
        exp_q = 0;
        seq   = 0;
        for (int c = 0; c < 34; c++) begin
            if (c >= 2) begin
                chk($sformatf("rr_valid_c%0d", c), 64'(phv_out_valid), 64'd1);
                chk($sformatf("rr_qid_c%0d", c), 64'(phv_out_qid), 64'(exp_q));
                if (phv_out_valid) sb_check($sformatf("rr_data_c%0d", c));
                exp_q = (exp_q + 1) % 4;
            end
            r4 = rdy();
            clear_push();
            for (int q = 0; q < 4; q++) begin
                if (r4[q]) begin
                    d = mk_phv(100 + seq, q);
                    push(q, d);
                    sb[q].push_back(d);
                    seq++;
                end
            end
            step();
        end
        clear_push();
        for (int k = 0; k < 40; k++) begin
            if (!phv_out_valid) break;
            sb_check($sformatf("rr_drain%0d", k));
            step();
        end
        chk("rr_drain_idle", 64'(phv_out_valid), 64'd0);
        total = sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
        chk("rr_all_delivered", 64'(total), 64'd0);

        // ---- back-pressure: queue 1 fills, fifth push dropped, output held ----
        do_reset();
        phv_out_ready = 1'b0;
        push(0, mk_phv(200, 0));
        step();
        clear_push();
        step();
        chk_beat("bp_hold_start", 2'd0, mk_phv(200, 0));
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_ready1_occ%0d", k), 64'(phv_fifo_ready_1), (k <= 2) ? 64'd1 : 64'd0);
            push(1, mk_phv(210 + k, 1));
            step();
            clear_push();
            chk_beat($sformatf("bp_hold%0d", k), 2'd0, mk_phv(200, 0));
        end
        chk("bp_drop1", 64'(drop_cnt_1), 64'(EXP_DROP_Q1));
        chk("bp_drop0", 64'(drop_cnt_0), 64'd0);
        chk("bp_ready1_full", 64'(phv_fifo_ready_1), 64'd0);
        step();
        step();
        chk_beat("bp_hold_end", 2'd0, mk_phv(200, 0));
        phv_out_ready = 1'b1;
        chk_beat("bp_out0", 2'd0, mk_phv(200, 0));
        step();
        for (int k = 0; k < 4; k++) begin
            chk_beat($sformatf("bp_out_q1_%0d", k), 2'd1, mk_phv(210 + k, 1));
            step();
        end
        chk("bp_idle", 64'(phv_out_valid), 64'd0);

        // ---- push and pop on a full queue 0 ----
        do_reset();
        phv_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push(0, mk_phv(300 + k, 0));
            step();
        end
        clear_push();
        chk("pp_ready0_full", 64'(phv_fifo_ready_0), 64'd0);
        chk_beat("pp_pending", 2'd0, mk_phv(300, 0));
        phv_out_ready = 1'b1;
        push(0, mk_phv(305, 0));
        step();
        clear_push();
        chk("pp_nodrop", 64'(drop_cnt_0), 64'd0);
        chk("pp_ready0_still_full", 64'(phv_fifo_ready_0), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            chk_beat($sformatf("pp_out%0d", k), 2'd0, mk_phv(300 + k, 0));
            step();
        end
        chk("pp_idle", 64'(phv_out_valid), 64'd0);

        // ---- reset with entries queued and an unaccepted output ----
        do_reset();
        phv_out_ready = 1'b0;
        push(1, mk_phv(400, 1));
        step();
        clear_push();
        push(1, mk_phv(401, 1));
        push(2, mk_phv(402, 2));
        push(3, mk_phv(403, 3));
        step();
        clear_push();
        chk_beat("mr_pending", 2'd1, mk_phv(400, 1));
        reset = 1'b1;
        step();
        chk("mr_valid", 64'(phv_out_valid), 64'd0);
        chk("mr_qid", 64'(phv_out_qid), 64'd0);
        chk_phv("mr_data", phv_out, '0);
        reset = 1'b0;
        #1;
        chk("mr_ready", 64'(rdy()), 64'hF);
        phv_out_ready = 1'b1;
        push(0, mk_phv(410, 0));
        push(3, mk_phv(413, 3));
        step();
        clear_push();
        step();
        chk_beat("mr_first", 2'd0, mk_phv(410, 0));
        step();
        chk_beat("mr_second", 2'd3, mk_phv(413, 3));
        step();
        chk("mr_idle", 64'(phv_out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
